syx_reg_arbiter: RTL

Arbitrates single-port access to the synth parameter register file (3-bit bank, 7-bit address, 8-bit data) between three requesters:

- **Requester 0:** the sysex patch/bank loader.
- **Requester 1:** the sysex patch-dump reader.
- **Requester 2:** the MIDI CC/panel controller.

The block uses round-robin arbitration with an optional bounded lock, so a patch load can stream without starvation. It sits between the synth controller front-ends and the register file in the `reg_clk` domain.

---
 rtl/synth_reg_pkg.sv | 42 ++++
 rtl/syx_reg_arbiter_rr_pick3.sv | 31 +++
 rtl/syx_reg_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/synth_reg_pkg.sv
// Shared types and constants for the synth parameter register-file access path.
package synth_reg_pkg;

  localparam int NUM_REQ = 3;
  localparam int BANK_W  = 3;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam int REQ_LOAD = 0;
  localparam int REQ_DUMP = 1;
  localparam int REQ_CTRL = 2;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_req_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RDWAIT,
    RDDONE
  } arb_state_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/syx_reg_arbiter_rr_pick3.sv
// Combinational round-robin one-hot selector for three requesters, priority starting at ptr.
module rr_pick3
  import synth_reg_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win
);

  logic [2:0] sum;
  logic [1:0] idx;

  // Walk from the farthest offset back to ptr so the nearest pending requester wins.
  always_comb begin
    win = '0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'(NUM_REQ)) begin
        sum = sum - 3'(NUM_REQ);
      end
      idx = sum[1:0];
      if (req[idx]) begin
        win = '0;
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/syx_reg_arbiter.sv
// Single-port register-file arbiter: round-robin between loader, dump reader and CC controller,
// with a bounded burst lock so a streaming patch load cannot starve the others.
module syx_reg_arbiter
  import synth_reg_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic                           reg_clk,
  input  logic                           reset_reg,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ-1:0][BANK_W-1:0] bank,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_W-1:0]              rdata,
  output logic [BANK_W-1:0]              rf_bank,
  output logic [ADDR_W-1:0]              rf_addr,
  output logic [DATA_W-1:0]              rf_wdata,
  output logic                           rf_we,
  output logic                           rf_re,
  input  logic [DATA_W-1:0]              rf_rdata,
  output logic                           busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t state, state_nxt;

  logic [1:0]         owner;
  logic               owner_vld;
  logic [1:0]         ptr;
  logic [CNT_W-1:0]   burst_cnt;

  reg_req_t [NUM_REQ-1:0] reqs;
  reg_req_t               sel;
  logic                   own_lock;
  logic [NUM_REQ-1:0]     owner_oh;
  logic [NUM_REQ-1:0]     rr_win;
  logic [NUM_REQ-1:0]     win_oh;
  logic [1:0]             win_idx;
  logic                   others_pend;
  logic                   lock_hold;
  logic                   any_req;

  function automatic logic [CNT_W-1:0] burst_next(input logic [CNT_W-1:0] cnt, input logic lk);
    logic [CNT_W-1:0] nxt;
    if (!lk) begin
      nxt = '0;
    end else if (cnt == CNT_W'(BURST_MAX)) begin
      nxt = cnt;
    end else begin
      nxt = cnt + 1'b1;
    end
    return nxt;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i] = '{we: we[i], lock: lock[i], bank: bank[i], addr: addr[i], wdata: wdata[i]};
    end
  end

  rr_pick3 u_pick (
    .req (req),
    .ptr (ptr),
    .win (rr_win)
  );

  // Previous owner keeps the port while locked, unless it has used up its burst and someone waits.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    own_lock        = reqs[owner].lock;
    others_pend     = |(req & ~owner_oh);
    lock_hold       = owner_vld && req[owner] && own_lock &&
                      ((burst_cnt < CNT_W'(BURST_MAX)) || !others_pend);
    win_oh          = lock_hold ? owner_oh : rr_win;
    win_idx         = onehot_idx(win_oh);
    sel             = reqs[win_idx];
    any_req         = |req;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = XFER;
      XFER:    state_nxt = rf_we ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = RDDONE;
      RDDONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      owner     <= '0;
      owner_vld <= 1'b0;
      ptr       <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      rf_bank   <= '0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      rf_we     <= 1'b0;
      rf_re     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      rf_re <= 1'b0;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win_oh;
            owner     <= win_idx;
            owner_vld <= 1'b1;
            ptr       <= next_ptr(win_idx);
            rf_bank   <= sel.bank;
            rf_addr   <= sel.addr;
            rf_wdata  <= sel.wdata;
            rf_we     <= sel.we;
            rf_re     <= ~sel.we;
            if (sel.we) begin
              ack <= win_oh;
            end
            if (!owner_vld || (win_idx != owner)) begin
              burst_cnt <= '0;
            end
          end
        end
        XFER: begin
          if (rf_we) begin
            gnt       <= '0;
            burst_cnt <= burst_next(burst_cnt, own_lock);
          end
        end
        // Register file returns data this cycle; ack goes out alongside the captured value.
        RDWAIT: begin
          rdata <= rf_rdata;
          ack   <= gnt;
        end
        RDDONE: begin
          gnt       <= '0;
          burst_cnt <= burst_next(burst_cnt, own_lock);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
